// File: rtl/ram64_pkg.sv
// ram64_pkg: shared definitions for the RAM64 two-port arbiter.
//   RAM64_AW / RAM64_DW : RAM geometry (64 x 16)
//   state_t             : arbiter FSM encoding
//   PORT_A / PORT_B     : requester identifiers used for owner and priority
package ram64_pkg;

    localparam int RAM64_AW = 6;
    localparam int RAM64_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram64_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector.
//   i_a_req, i_b_req : pending requests
//   i_prio           : port that wins when both request
//   o_gnt_valid      : at least one request present
//   o_gnt_id         : selected port (PORT_A / PORT_B)
module rr_pick2
    import ram64_pkg::*;
(
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_prio,
    output logic o_gnt_valid,
    output logic o_gnt_id
);

    always_comb begin
        o_gnt_valid = i_a_req | i_b_req;
        o_gnt_id    = PORT_A;
        if (i_a_req && i_b_req) begin
            o_gnt_id = i_prio;
        end else if (i_b_req) begin
            o_gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/ram64_arbiter.sv
// ram64_arbiter: shares one synchronous RAM64 between two req/ack ports.
//   clk, rst_n                 : clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata  : port A request (held until a_ack)
//   a_ack, a_rdata             : port A completion pulse and read data
//   b_*                        : same as port A, for port B
//   ram_e/ram_w/ram_r          : RAM enable, write and read strobes
//   ram_addr/ram_din           : RAM address and write data
//   ram_dout                   : RAM read data, valid RD_LAT cycles after ram_r
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate and latch the winner's fields
// ST_ISSUE | one cycle with ram_e and the read/write strobe asserted
// ST_WAIT  | read latency beyond one cycle; ram_e and address held
// ST_DONE  | owner's ack pulse; read data already captured; prio flips
module ram64_arbiter
    import ram64_pkg::*;
#(
    parameter int AW     = RAM64_AW,
    parameter int DW     = RAM64_DW,
    parameter int RD_LAT = 1
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          ram_e,
    output logic          ram_w,
    output logic          ram_r,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic          r_we;
    logic          r_prio;
    logic [1:0]    r_lat_cnt;

    logic          w_gnt_valid;
    logic          w_gnt_id;
    logic          w_grant;
    logic          w_to_done;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    rr_pick2 u_pick (
        .i_a_req     (a_req),
        .i_b_req     (b_req),
        .i_prio      (r_prio),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    always_comb begin
        w_sel_we    = (w_gnt_id == PORT_B) ? b_we    : a_we;
        w_sel_addr  = (w_gnt_id == PORT_B) ? b_addr  : a_addr;
        w_sel_wdata = (w_gnt_id == PORT_B) ? b_wdata : a_wdata;
    end

    // Next-state logic. Requests are only looked at in ST_IDLE, so the
    // owner's own req (or the other port's) cannot disturb a transaction.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_grant = 1'b1;
                    w_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_we || (RD_LAT <= 1)) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter reaches zero on the edge that enters ST_DONE.
                if (r_lat_cnt <= 2'd1) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_to_done = (w_next == ST_DONE) && (r_state != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= PORT_A;
            r_we      <= 1'b0;
            r_prio    <= PORT_A;
            r_lat_cnt <= 2'd0;
        end else begin
            if (w_grant) begin
                r_owner <= w_gnt_id;
                r_we    <= w_sel_we;
            end
            if (r_state == ST_ISSUE && !r_we) begin
                r_lat_cnt <= LAT_LOAD;
            end else if (r_state == ST_WAIT && r_lat_cnt != 2'd0) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            if (r_state == ST_DONE) begin
                r_prio <= ~r_owner;
            end
        end
    end

    // RAM side: strobes are high only for the ST_ISSUE cycle, enable spans
    // ST_ISSUE and ST_WAIT, address/data hold from grant to the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_e    <= 1'b0;
            ram_w    <= 1'b0;
            ram_r    <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_e <= (w_next == ST_ISSUE) || (w_next == ST_WAIT);
            ram_w <= 1'b0;
            ram_r <= 1'b0;
            if (w_grant) begin
                ram_w    <= w_sel_we;
                ram_r    <= ~w_sel_we;
                ram_addr <= w_sel_addr;
                ram_din  <= w_sel_wdata;
            end
        end
    end

    // Read data is captured on the same edge that raises ack, so it is
    // valid in the ack cycle and held until that port's next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_ack <= w_to_done && (r_owner == PORT_A);
            b_ack <= w_to_done && (r_owner == PORT_B);
            if (w_to_done && !r_we) begin
                if (r_owner == PORT_A) begin
                    a_rdata <= ram_dout;
                end else begin
                    b_rdata <= ram_dout;
                end
            end
        end
    end

endmodule
